rx_deserializer: RTL and testbench

RX_DESERIALIZER -- requirements
Module: rx_deserializer

---
 rtl/rx_deserializer.sv | 162 ++++++++++++++++
 tb/tb_rx_deserializer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : rx_deserializer
// Description : Serial-to-parallel receive framer. Consumes pre-sampled line
//               bits on i_bit_stb, detects the start bit, assembles
//               DATA_WIDTH data bits (LSB- or MSB-first), optionally checks
//               one parity bit, checks STOP_BITS stop bits and presents the
//               word with error flags on a valid/ready output.
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous reset, active low
//               i_rx_bit     - sampled serial line value
//               i_bit_stb    - one-cycle strobe qualifying i_rx_bit
//               o_data_out   - last completed data word
//               o_data_valid - o_data_out holds an unconsumed word
//               i_data_ready - consumer accepts the word
//               o_parity_err - parity mismatch on the presented word
//               o_frame_err  - a stop bit of the presented word was 0
//               o_overrun    - a completed word replaced an unconsumed one
//               o_busy       - receiver is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int MSB_FIRST  = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rx_bit,
    input  logic                  i_bit_stb,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_overrun,
    output logic                  o_busy
);

    localparam int              c_CW        = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST_BIT  = c_CW'(DATA_WIDTH - 1);
    localparam logic            c_STOP_LAST = (STOP_BITS == 2);
    localparam logic            c_ODD       = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [c_CW-1:0]         r_cnt;
    logic                    r_stop_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_par;
    logic                    r_ferr_acc;   // earlier stop bit of this frame was 0
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_perr;
    logic                    r_ferr;
    logic                    r_ovr;
    logic                    r_busy;

    logic                    w_complete;
    logic                    w_transfer;
    logic                    w_perr;
    logic                    w_ferr;

    // The final stop bit is being sampled on this edge.
    assign w_complete = i_bit_stb && (r_state == S_STOP) && (r_stop_cnt == c_STOP_LAST);
    assign w_transfer = r_valid && i_data_ready;
    assign w_perr     = (PARITY_EN != 0) ? ((^r_shift) ^ r_par ^ c_ODD) : 1'b0;
    assign w_ferr     = r_ferr_acc | ~i_rx_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            // ---------------- framing FSM ----------------
            if (i_bit_stb) begin
                case (r_state)
                    S_IDLE: begin
                        if (!i_rx_bit) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (MSB_FIRST != 0) begin
                            r_shift <= {r_shift[DATA_WIDTH-2:0], i_rx_bit};
                        end else begin
                            r_shift <= {i_rx_bit, r_shift[DATA_WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST_BIT) begin
                            r_stop_cnt <= 1'b0;
                            r_ferr_acc <= 1'b0;
                            r_state    <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end
                    S_PARITY: begin
                        r_par      <= i_rx_bit;
                        r_stop_cnt <= 1'b0;
                        r_ferr_acc <= 1'b0;
                        r_state    <= S_STOP;
                    end
                    S_STOP: begin
                        if (r_stop_cnt == c_STOP_LAST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stop_cnt <= 1'b1;
                            r_ferr_acc <= ~i_rx_bit;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end

            // ---------------- output handshake ----------------
            // A completion wins over a transfer: the new word loads, and
            // overrun records whether the previous word was lost unread.
            if (w_complete) begin
                r_data  <= r_shift;
                r_perr  <= w_perr;
                r_ferr  <= w_ferr;
                r_valid <= 1'b1;
                r_ovr   <= r_valid & ~i_data_ready;
            end else if (w_transfer) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign o_data_out   = r_data;
    assign o_data_valid = r_valid;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_ferr;
    assign o_overrun    = r_ovr;
    assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_deserializer
// Description : Self-checking bench for rx_deserializer. Five instances cover
//               8N1 LSB-first, MSB-first, even parity, odd parity and a
//               5-bit two-stop-bit configuration. Expected words are queued
//               when a frame is driven and compared when the word appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_deserializer;

    localparam int c_N = 5;

    typedef struct {
        int         k;
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk;
    logic rst;
    logic r_rx   [c_N];
    logic r_stb  [c_N];
    logic r_rdy  [c_N];
    logic w_vld  [c_N];
    logic w_perr [c_N];
    logic w_ferr [c_N];
    logic w_ovr  [c_N];
    logic w_busy [c_N];
    logic [7:0] w_d0, w_d1, w_d2, w_d3;
    logic [4:0] w_d4;

    int W_TAB   [c_N] = '{8, 8, 8, 8, 5};
    int MSB_TAB [c_N] = '{0, 1, 0, 0, 0};
    int PEN_TAB [c_N] = '{0, 0, 1, 1, 0};
    int ODD_TAB [c_N] = '{0, 0, 0, 1, 0};
    int STP_TAB [c_N] = '{1, 1, 1, 1, 2};

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rx_deserializer #(.DATA_WIDTH(8)) u_lsb (
        .clk(clk), .rst(rst), .i_rx_bit(r_rx[0]), .i_bit_stb(r_stb[0]),
        .o_data_out(w_d0), .o_data_valid(w_vld[0]), .i_data_ready(r_rdy[0]),
        .o_parity_err(w_perr[0]), .o_frame_err(w_ferr[0]),
        .o_overrun(w_ovr[0]), .o_busy(w_busy[0]));

    rx_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .i_rx_bit(r_rx[1]), .i_bit_stb(r_stb[1]),
        .o_data_out(w_d1), .o_data_valid(w_vld[1]), .i_data_ready(r_rdy[1]),
        .o_parity_err(w_perr[1]), .o_frame_err(w_ferr[1]),
        .o_overrun(w_ovr[1]), .o_busy(w_busy[1]));

    rx_deserializer #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) u_pev (
        .clk(clk), .rst(rst), .i_rx_bit(r_rx[2]), .i_bit_stb(r_stb[2]),
        .o_data_out(w_d2), .o_data_valid(w_vld[2]), .i_data_ready(r_rdy[2]),
        .o_parity_err(w_perr[2]), .o_frame_err(w_ferr[2]),
        .o_overrun(w_ovr[2]), .o_busy(w_busy[2]));

    rx_deserializer #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1)) u_pod (
        .clk(clk), .rst(rst), .i_rx_bit(r_rx[3]), .i_bit_stb(r_stb[3]),
        .o_data_out(w_d3), .o_data_valid(w_vld[3]), .i_data_ready(r_rdy[3]),
        .o_parity_err(w_perr[3]), .o_frame_err(w_ferr[3]),
        .o_overrun(w_ovr[3]), .o_busy(w_busy[3]));

    rx_deserializer #(.DATA_WIDTH(5), .STOP_BITS(2)) u_2stop (
        .clk(clk), .rst(rst), .i_rx_bit(r_rx[4]), .i_bit_stb(r_stb[4]),
        .o_data_out(w_d4), .o_data_valid(w_vld[4]), .i_data_ready(r_rdy[4]),
        .o_parity_err(w_perr[4]), .o_frame_err(w_ferr[4]),
        .o_overrun(w_ovr[4]), .o_busy(w_busy[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [8:0] dout_of(input int k);
        case (k)
            0:       return {1'b0, w_d0};
            1:       return {1'b0, w_d1};
            2:       return {1'b0, w_d2};
            3:       return {1'b0, w_d3};
            default: return {4'b0, w_d4};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobed bit; returns on the falling edge after it was consumed.
    task automatic drive_bit(input int k, input logic b, input logic rdy);
        @(negedge clk);
        r_rx[k]  = b;
        r_stb[k] = 1'b1;
        r_rdy[k] = rdy;
        @(negedge clk);
        r_stb[k] = 1'b0;
        r_rdy[k] = 1'b0;
    endtask

    task automatic consume(input int k);
        @(negedge clk);
        r_rdy[k] = 1'b1;
        @(negedge clk);
        r_rdy[k] = 1'b0;
    endtask

    // Drives a full frame and queues the word the receiver must present.
    task automatic send_frame(input int k, input logic [8:0] d, input logic pbit,
                              input logic [1:0] stops, input logic rdy_last);
        exp_t       e;
        logic [8:0] m;
        m    = d & ((9'd1 << W_TAB[k]) - 9'd1);
        e.k  = k;
        e.d  = m;
        e.pe = (PEN_TAB[k] != 0) ? ((^m) ^ pbit ^ ODD_TAB[k][0]) : 1'b0;
        e.fe = (STP_TAB[k] == 2) ? ~(stops[0] & stops[1]) : ~stops[0];
        drive_bit(k, 1'b0, 1'b0);
        for (int i = 0; i < W_TAB[k]; i++) begin
            drive_bit(k, (MSB_TAB[k] != 0) ? m[W_TAB[k]-1-i] : m[i], 1'b0);
        end
        if (PEN_TAB[k] != 0) drive_bit(k, pbit, 1'b0);
        sb.push_back(e);
        for (int s = 0; s < STP_TAB[k]; s++) begin
            drive_bit(k, stops[s], (s == STP_TAB[k] - 1) ? rdy_last : 1'b0);
        end
    endtask

    task automatic check_word(input string tag, input logic exp_ovr);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_valid"}, 32'(w_vld[e.k]), 32'd1);
        chk({tag, "_data"},  32'(dout_of(e.k)), 32'(e.d));
        chk({tag, "_perr"},  32'(w_perr[e.k]), 32'(e.pe));
        chk({tag, "_ferr"},  32'(w_ferr[e.k]), 32'(e.fe));
        chk({tag, "_ovr"},   32'(w_ovr[e.k]),  32'(exp_ovr));
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < c_N; k++) begin
            r_rx[k] = 1'b1; r_stb[k] = 1'b0; r_rdy[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < c_N; k++) begin
            chk("rst_valid", 32'(w_vld[k]), 32'd0);
            chk("rst_data",  32'(dout_of(k)), 32'd0);
            chk("rst_busy",  32'(w_busy[k]), 32'd0);
            chk("rst_flags", {29'd0, w_perr[k], w_ferr[k], w_ovr[k]}, 32'd0);
        end
        rst = 1'b1;

        // 8N1 LSB-first 0xA5
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0);
        check_word("lsb_a5", 1'b0);
        consume(0);
        chk("lsb_consumed", 32'(w_vld[0]), 32'd0);
        chk("lsb_hold_data", 32'(dout_of(0)), 32'h0A5);

        // framing error still delivered, then a clean frame
        send_frame(0, 9'h081, 1'b0, 2'b10, 1'b0);
        check_word("ferr", 1'b0);
        consume(0);
        send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b0);
        check_word("after_ferr_3c", 1'b0);
        consume(0);

        // overrun: two unconsumed words, then one transfer
        send_frame(0, 9'h011, 1'b0, 2'b11, 1'b0);
        check_word("ovr_11", 1'b0);
        send_frame(0, 9'h022, 1'b0, 2'b11, 1'b0);
        check_word("ovr_22", 1'b1);
        consume(0);
        chk("ovr_clr_valid", 32'(w_vld[0]), 32'd0);
        chk("ovr_clr_ovr",   32'(w_ovr[0]), 32'd0);

        // completion coincident with a transfer of the previous word
        send_frame(0, 9'h033, 1'b0, 2'b11, 1'b0);
        check_word("coinc_33", 1'b0);
        send_frame(0, 9'h044, 1'b0, 2'b11, 1'b1);
        check_word("coinc_44", 1'b0);
        consume(0);

        // reset after the 4th data bit aborts the frame
        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, i[0], 1'b0);
        chk("mid_busy", 32'(w_busy[0]), 32'd1);
        rst = 1'b0;
        #2;
        chk("abort_busy",  32'(w_busy[0]), 32'd0);
        chk("abort_valid", 32'(w_vld[0]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, 1'b0);
        chk("idle_valid", 32'(w_vld[0]), 32'd0);
        chk("idle_busy",  32'(w_busy[0]), 32'd0);
        send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b0);
        check_word("post_rst_5a", 1'b0);
        consume(0);
        chk("post_rst_empty", 32'(sb.size()), 32'd0);

        // MSB-first
        send_frame(1, 9'h0A5, 1'b0, 2'b11, 1'b0);
        check_word("msb_a5", 1'b0);
        consume(1);
        send_frame(1, 9'h0F0, 1'b0, 2'b11, 1'b0);
        check_word("msb_f0", 1'b0);
        chk("msb_f0_const", 32'(dout_of(1)), 32'h0F0);
        consume(1);

        // parity
        send_frame(2, 9'h0A5, 1'b1, 2'b11, 1'b0);
        check_word("even_p1", 1'b0);
        chk("even_p1_const", 32'(w_perr[2]), 32'd1);
        consume(2);
        send_frame(2, 9'h0A5, 1'b0, 2'b11, 1'b0);
        check_word("even_p0", 1'b0);
        consume(2);
        send_frame(3, 9'h0A5, 1'b1, 2'b11, 1'b0);
        check_word("odd_p1", 1'b0);
        consume(3);
        send_frame(3, 9'h0A5, 1'b0, 2'b11, 1'b0);
        check_word("odd_p0", 1'b0);
        chk("odd_p0_const", 32'(w_perr[3]), 32'd1);
        consume(3);

        // 5-bit, two stop bits
        send_frame(4, 9'h015, 1'b0, 2'b11, 1'b0);
        check_word("s2_good", 1'b0);
        consume(4);
        send_frame(4, 9'h00A, 1'b0, 2'b01, 1'b0);
        check_word("s2_second_bad", 1'b0);
        consume(4);
        send_frame(4, 9'h013, 1'b0, 2'b10, 1'b0);
        check_word("s2_first_bad", 1'b0);
        consume(4);
        drive_bit(4, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(4, 1'b1, 1'b0);
        drive_bit(4, 1'b1, 1'b0);
        chk("s2_busy_after_first_stop", 32'(w_busy[4]), 32'd1);
        chk("s2_no_word_yet", 32'(w_vld[4]), 32'd0);
        drive_bit(4, 1'b1, 1'b0);
        chk("s2_word_after_second", 32'(w_vld[4]), 32'd1);
        chk("s2_idle_after_second", 32'(w_busy[4]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
